// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo
// Purpose : 8N1 UART receiver feeding a small first-word-fall-through FIFO
//           that a valid/ready consumer drains.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset (0 = reset)
//   rx         in   serial line, idle high, asynchronous to clk
//   rd_ready   in   consumer accepts the head byte this cycle
//   rd_data    out  FIFO head byte, valid when rd_valid=1
//   rd_valid   out  FIFO non-empty
//   fifo_count out  number of bytes held (0..FIFO_DEPTH)
//   stop_error out  one-cycle pulse: stop bit sampled low
//   overflow   out  one-cycle pulse: good byte dropped, FIFO was full
// ============================================================================
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_ready,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          stop_error,
  output logic                          overflow
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);

  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_ptr_w:0]   c_depth     = (c_ptr_w + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer; resets to the idle (high) line level so a reset
  // never looks like a start bit.
  // --------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic [c_cnt_w-1:0]   r_clk_cnt;
  logic [2:0]           r_bit_cnt;
  logic [7:0]           r_shift;
  logic                 r_stop_error;

  logic w_tick_half;
  logic w_tick_bit;
  logic w_push;

  assign w_tick_half = (r_clk_cnt == c_half_last);
  assign w_tick_bit  = (r_clk_cnt == c_bit_last);
  // r_shift already holds the full byte when the stop bit is sampled.
  assign w_push      = (r_state == S_STOP) && w_tick_bit && r_rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_stop_error <= 1'b0;
    end else begin
      r_stop_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          if (!r_rx_s) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          // Half a bit in: re-check the line to reject short glitches and
          // align all later samples to mid-bit.
          if (w_tick_half) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick_bit) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick_bit) begin
            r_clk_cnt <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_stop_error <= 1'b1;
              r_state      <= S_WAIT_HIGH;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          // A held-low line (break) must not be decoded as further frames.
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // --------------------------------------------------------------------------
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               r_overflow;

  logic w_full;
  logic w_pop;
  logic w_wr_en;

  assign w_full  = (r_count == c_depth);
  assign w_pop   = rd_valid && rd_ready;
  // When full, a same-cycle pop frees the slot the write pointer points at.
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push && w_full && !w_pop;
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data    = r_mem[r_rd_ptr];
  assign rd_valid   = (r_count != '0);
  assign fifo_count = r_count;
  assign stop_error = r_stop_error;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_fifo
// Purpose : Self-checking bench for uart_rx_fifo. Frames are driven on rx;
//           a queue-based reference model predicts received bytes, drops and
//           framing errors; a monitor compares every consumed byte.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  // Cycle within a frame (counted from the start-bit drive) in which the
  // receiver takes its stop-bit sample: 2 sync + CPB/2 + 9*CPB.
  localparam int STOP_CYC = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       stop_error;
  logic       overflow;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .fifo_count(fifo_count),
    .stop_error(stop_error),
    .overflow  (overflow)
  );

  logic [7:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int exp_ovf = 0;
  int exp_serr = 0;
  int obs_ovf = 0;
  int obs_serr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts pulses and checks every consumed byte against the model.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (stop_error) obs_serr++;
        if (overflow) obs_ovf++;
        if (stop_error && overflow) chk("serr_ovf_exclusive", 32'd1, 32'd0);
        if (rd_valid && rd_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pop", {24'd0, rd_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("pop_data", {24'd0, rd_data}, {24'd0, e});
          end
        end
      end
    end
  end

  // rmode: 0 = leave rd_ready alone, 1 = random every cycle,
  //        2 = rd_ready high only in the stop-sample cycle.
  task automatic send_frame(input logic [7:0] b, input logic stopb,
                            input int rmode, input int abort_at);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c == abort_at) return;
      rx = f[c / CPB];
      if (rmode == 1) rd_ready = 1'($urandom_range(0, 1));
      else if (rmode == 2) rd_ready = (c == STOP_CYC);
      if (c == STOP_CYC) begin
        if (!stopb) exp_serr++;
        else if (exp_q.size() == DEPTH && !(rd_ready && exp_q.size() > 0)) exp_ovf++;
        else exp_q.push_back(b);
      end
      @(posedge clk); #1;
    end
    chk("count_after_frame", {29'd0, fifo_count}, exp_q.size());
  endtask

  task automatic idle(input int n, input logic lvl, input int rmode);
    for (int i = 0; i < n; i++) begin
      rx = lvl;
      if (rmode == 1) rd_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_model_empty", exp_q.size(), 0);
    rd_ready = 1'b0;
    chk("drain_valid", {31'd0, rd_valid}, 0);
    chk("drain_count", {29'd0, fifo_count}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       sb;

    // 1. Reset with rx toggling, then idle line.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx = ~rx;
      @(posedge clk); #1;
    end
    chk("rst_valid", {31'd0, rd_valid}, 0);
    chk("rst_count", {29'd0, fifo_count}, 0);
    chk("rst_data", {24'd0, rd_data}, 0);
    chk("rst_serr", {31'd0, stop_error}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    rx  = 1'b1;
    rst = 1'b1;
    idle(3 * CPB, 1'b1, 0);
    chk("idle_count", {29'd0, fifo_count}, 0);
    chk("idle_valid", {31'd0, rd_valid}, 0);
    chk("idle_serr_cnt", obs_serr, exp_serr);

    // 2. Single byte, one-cycle read.
    send_frame(8'hA5, 1'b1, 0, -1);
    chk("single_valid", {31'd0, rd_valid}, 1);
    chk("single_data", {24'd0, rd_data}, {24'd0, exp_q[0]});
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    chk("single_count_after_pop", {29'd0, fifo_count}, 0);
    chk("single_valid_after_pop", {31'd0, rd_valid}, 0);

    // 3. Fill back to back, overflow, drain in order.
    send_frame(8'hAA, 1'b1, 0, -1);
    send_frame(8'hCC, 1'b1, 0, -1);
    send_frame(8'h0F, 1'b1, 0, -1);
    send_frame(8'hF0, 1'b1, 0, -1);
    send_frame(8'h55, 1'b1, 0, -1);
    chk("fill_ovf_cnt", obs_ovf, exp_ovf);
    drain();

    // 4. Push and pop in the same cycle while full.
    send_frame(8'h11, 1'b1, 0, -1);
    send_frame(8'h22, 1'b1, 0, -1);
    send_frame(8'h33, 1'b1, 0, -1);
    send_frame(8'h44, 1'b1, 0, -1);
    send_frame(8'h77, 1'b1, 2, -1);
    idle(4, 1'b1, 0);
    chk("pushpop_ovf_cnt", obs_ovf, exp_ovf);
    chk("pushpop_count", {29'd0, fifo_count}, 4);
    drain();

    // 5. Framing error followed by a break, then a good frame.
    send_frame(8'h3C, 1'b0, 0, -1);
    idle(20 * CPB, 1'b0, 0);
    idle(2 * CPB, 1'b1, 0);
    chk("break_serr_cnt", obs_serr, exp_serr);
    chk("break_count", {29'd0, fifo_count}, 0);
    send_frame(8'h81, 1'b1, 0, -1);
    chk("after_break_data", {24'd0, rd_data}, 32'h81);
    drain();

    // 6. Start-bit glitch, then reset in the middle of a frame.
    idle(4, 1'b0, 0);
    idle(3 * CPB, 1'b1, 0);
    chk("glitch_count", {29'd0, fifo_count}, 0);
    chk("glitch_serr_cnt", obs_serr, exp_serr);
    send_frame(8'h5A, 1'b1, 0, 4 * CPB + 5);
    rx  = 1'b1;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("midrst_valid", {31'd0, rd_valid}, 0);
    chk("midrst_count", {29'd0, fifo_count}, 0);
    chk("midrst_serr", {31'd0, stop_error}, 0);
    rst = 1'b1;
    idle(CPB, 1'b1, 0);
    send_frame(8'h5A, 1'b1, 0, -1);
    chk("midrst_resend_data", {24'd0, rd_data}, 32'h5A);
    drain();

    // 7. Random frames with random consumer back-pressure.
    for (int n = 0; n < 24; n++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      send_frame(b, sb, 1, -1);
      if (!sb) idle(CPB, 1'b1, 1);
    end
    idle(4, 1'b1, 0);
    drain();
    chk("rand_serr_cnt", obs_serr, exp_serr);
    chk("rand_ovf_cnt", obs_ovf, exp_ovf);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
